// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

    // ALU operand source select.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,   // register file value read in Decode
        FWD_WB  = 2'b01,   // result sitting in Writeback
        FWD_MEM = 2'b10    // ALU result sitting in Memory
    } fwd_sel_t;

    // Memory-wait tracking state.
    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam int REG_W      = 5;   // register index width
    localparam int WAIT_W     = 4;   // wait counter width
    localparam int WAIT_LIMIT = 15;  // wait count at which a still-pending access times out
    localparam int CNT_W      = 16;  // performance counter width

    // Increment a performance counter, holding at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                 input logic             en);
        if (en && (value != '1)) begin
            return value + 1'b1;
        end
        return value;
    endfunction

endpackage

// File: rtl/forward_unit.sv
// Operand forwarding select for one ALU source. Memory beats Writeback because
// it holds the younger result; register x0 is never forwarded.
module forward_unit
    import pipe_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rd_m,
    input  logic [REG_W-1:0] rd_w,
    input  logic             reg_write_m,
    input  logic             reg_write_w,
    output fwd_sel_t         sel
);

    // Priority select: Memory, then Writeback, then register file.
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        sel = FWD_RF;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
            sel = FWD_MEM;
        end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stall, taken-branch flush,
// memory-wait freeze with sticky timeout, and saturating performance counters.
// Stall, flush and forward outputs are purely combinational; the registered
// state only feeds the counters and the timeout flag.
module hazard_ctrl
    import pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic [REG_W-1:0] Rs1E,
    input  logic [REG_W-1:0] Rs2E,
    input  logic [REG_W-1:0] RdE,
    input  logic             ResultSrcE0,
    input  logic             PCSrcE,
    input  logic [REG_W-1:0] RdM,
    input  logic [REG_W-1:0] RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount
);

    logic              mem_wait;
    logic              lw_stall;
    fwd_sel_t          fwd_a;
    fwd_sel_t          fwd_b;
    state_t            state_q;
    state_t            state_d;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_d;
    logic              timeout_q;
    logic              timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_q;

    // Data memory has been asked for something it has not delivered yet.
    assign mem_wait = MemReqM & ~MemReadyM;

    // Load result needed by the instruction in Decode; a taken branch kills
    // that instruction anyway, so no stall is needed then.
    assign lw_stall = ResultSrcE0 & (RdE != '0) & ((RdE == Rs1D) | (RdE == Rs2D)) & ~PCSrcE;

    forward_unit u_fwd_a (
        .rs          (Rs1E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .sel         (fwd_a)
    );

    forward_unit u_fwd_b (
        .rs          (Rs2E),
        .rd_m        (RdM),
        .rd_w        (RdW),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .sel         (fwd_b)
    );

    // Stage control: reset bubbles every stage, a memory wait freezes F..M and
    // bubbles W (a pending branch flush is held until the wait ends), otherwise
    // normal load-use stall and branch flush.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (!rst_n) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else begin
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
            if (mem_wait) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else begin
                StallF = lw_stall;
                StallD = lw_stall;
                FlushD = PCSrcE;
                FlushE = lw_stall | PCSrcE;
            end
        end
    end

    // Next state: enter MEM_WAIT on a pending access, leave as soon as it completes.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:      if (mem_wait)  state_d = MEM_WAIT;
            MEM_WAIT: if (!mem_wait) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    // Wait counter and timeout: the counter tracks elapsed wait cycles
    // (the cycle that enters MEM_WAIT counts as the first), clears once the
    // FSM is back in RUN, and saturates at the limit. Reaching the limit with
    // the access still pending latches the timeout until reset.
    always_comb begin
        wait_cnt_d = '0;
        timeout_d  = timeout_q;
        if (mem_wait) begin
            if (wait_cnt_q == WAIT_W'(WAIT_LIMIT)) begin
                wait_cnt_d = wait_cnt_q;
                timeout_d  = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end else if (state_q == MEM_WAIT) begin
            wait_cnt_d = '0;
        end
    end

    // State, wait tracking and performance counters.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= sat_inc(stall_cnt_q, StallF);
            flush_cnt_q <= sat_inc(flush_cnt_q, PCSrcE & ~mem_wait);
        end
    end

    assign MemTimeout  = timeout_q;
    assign StallCycles = stall_cnt_q;
    assign FlushCount  = flush_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Rs1D, Rs2D  in  5 each  source register indices in Decode
- Rs1E, Rs2E, RdE  in  5 each  source and destination indices in Execute
- ResultSrcE0  in  1  Execute instruction is a load
- PCSrcE  in  1  branch or jump taken in Execute
- RdM, RdW  in  5 each  destination indices in Memory and Writeback
- RegWriteM, RegWriteW  in  1 each  register-write enables in Memory and Writeback
- MemReqM  in  1  Memory-stage instruction accesses data memory
- MemReadyM  in  1  data memory completes the access this cycle
- StallF, StallD, StallE, StallM  out  1 each  hold the named stage register
- FlushD, FlushE, FlushW  out  1 each  bubble the named stage register
- ForwardAE, ForwardBE  out  2 each  ALU operand source select
- MemTimeout  out  1  sticky memory-wait timeout error
- StallCycles, FlushCount  out  16 each  saturating performance counters
REQ-002 SHALL use one clock, clk; reset is rst_n, asynchronous and active-low.

Function
REQ-003 ForwardAE SHALL be 2'b10 when RegWriteM, RdM!=0 and RdM==Rs1E; else 2'b01 when RegWriteW, RdW!=0 and RdW==Rs1E; else 2'b00. ForwardBE SHALL follow the same rule using Rs2E.
REQ-004 Memory priority SHALL take precedence over Writeback when both match.
REQ-005 lwStall SHALL equal ResultSrcE0 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D) & !PCSrcE, so a taken branch suppresses load-use stall.
REQ-006 memWait SHALL equal MemReqM & !MemReadyM.
REQ-007 FSM states SHALL be RUN and MEM_WAIT.
REQ-008 The FSM SHALL go RUN->MEM_WAIT on memWait, stay in MEM_WAIT while memWait, and return MEM_WAIT->RUN on the first cycle MemReadyM=1.
REQ-009 When memWait=1, the block SHALL assert StallF=StallD=StallE=StallM=1 and FlushW=1, and hold FlushD=FlushE=0; the held PCSrcE takes effect on the cycle memWait drops.
REQ-010 When memWait=0, the block SHALL drive StallF=StallD=lwStall, FlushD=PCSrcE, FlushE=lwStall|PCSrcE, and StallE=StallM=FlushW=0.
REQ-011 All stall, flush and forward outputs SHALL be combinational in their inputs; state affects only the counters and the timeout.
REQ-012 A 4-bit wait counter SHALL clear in RUN and increment each MEM_WAIT cycle; at value 15 with memWait still 1, MemTimeout SHALL set and remain 1 until reset; stalling SHALL continue.
REQ-013 StallCycles SHALL increment on every cycle with StallF=1 and saturate at 16'hFFFF.
REQ-014 FlushCount SHALL increment on every cycle with PCSrcE=1 and memWait=0, and saturate at 16'hFFFF.

Reset
REQ-015 While rst_n=0, the block SHALL hold state=RUN, the wait counter at 0, MemTimeout=0, StallCycles=0 and FlushCount=0.
REQ-016 While rst_n=0, the block SHALL force FlushD=FlushE=FlushW=1, all Stall outputs=0, and ForwardAE=ForwardBE=2'b00.
REQ-017 Reset asserted mid-MEM_WAIT SHALL abort the wait immediately; after release the FSM SHALL start in RUN.

Structure
REQ-018 Package pipe_pkg SHALL hold the fwd_sel enum (FWD_RF=00, FWD_WB=01, FWD_MEM=10), the state enum, and the constants WAIT_LIMIT=15 and CNT_W=16.
REQ-019 Forwarding SHALL be one sub-module, forward_unit, instantiated once per operand.

Verification
REQ-020 Stimulus RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10. Same with RdM=0 -> ForwardAE=01.
REQ-021 Load in E with RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for exactly one cycle and StallCycles+1. The same case with PCSrcE=1 -> StallF=0, FlushD=FlushE=1 and FlushCount+1.
REQ-022 MemReqM=1 with MemReadyM=0 for 3 cycles, then 1 -> the four Stall outputs and FlushW=1 for 3 cycles; the FSM returns to RUN on the 4th cycle; MemTimeout stays 0.
REQ-023 MemReadyM held 0 for 20 cycles -> MemTimeout=1 from the 16th wait cycle; it stays 1 after MemReadyM=1 and clears only on rst_n=0.
REQ-024 Force StallCycles to 16'hFFFE via 65534 stall cycles, then apply 3 more -> the counter holds 16'hFFFF.
REQ-025 Assert rst_n=0 during MEM_WAIT -> outputs take their reset values immediately; after release, the state is RUN and the counters read 0.
